pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/load_use_detect.sv | 15 +
 rtl/pipeline_hazard_ctrl.sv | 139 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_MD   = 2'd2
  } state_e;

  // x0 is hard-wired zero, so it never creates a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // The eight stall/flush controls, assembled internally then fanned out to ports.
  typedef struct packed {
    logic f_stall;
    logic fd_stall;
    logic fd_flush;
    logic de_stall;
    logic de_flush;
    logic em_stall;
    logic em_flush;
    logic mw_stall;
  } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector between the ID and EX stages.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] D_rs1,
  input  logic [4:0] D_rs2,
  input  logic [4:0] E_rd,
  input  logic       E_mem_read,
  output logic       hazard
);

  // A load in EX whose destination feeds either source of the ID instruction.
  assign hazard = E_mem_read && (E_rd != REG_ZERO) && ((E_rd == D_rs1) || (E_rd == D_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: boot bubbling, memory waits,
// MUL/DIV occupancy of EX, branch redirects and load-use bubbles.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_CYCLES   = 4,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       D_rs1,
  input  logic [4:0]       D_rs2,
  input  logic [4:0]       E_rd,
  input  logic             E_mem_read,
  input  logic             E_branch_taken,
  input  logic             E_md_start,
  input  logic             imem_wait,
  input  logic             dmem_wait,
  output logic             F_stall,
  output logic             FD_stall,
  output logic             FD_flush,
  output logic             DE_stall,
  output logic             DE_flush,
  output logic             EM_stall,
  output logic             EM_flush,
  output logic             MW_stall,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [7:0] BootLoad = 8'(BOOT_CYCLES - 1);
  localparam logic [7:0] MdLoad   = 8'(MD_CYCLES - 2);

  state_e           state_q, state_d;
  logic [7:0]       boot_cnt_q, boot_cnt_d;
  logic [7:0]       md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             load_use;
  logic             md_busy;
  ctrl_t            ctrl;

  load_use_detect u_load_use_detect (
    .D_rs1      (D_rs1),
    .D_rs2      (D_rs2),
    .E_rd       (E_rd),
    .E_mem_read (E_mem_read),
    .hazard     (load_use)
  );

  assign md_busy = ((state_q == S_RUN) && E_md_start) || (state_q == S_MD);

  // State, counters and the saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_BOOT;
      boot_cnt_q  <= BootLoad;
      md_cnt_q    <= 8'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      md_cnt_q   <= md_cnt_d;
      if ((state_q != S_BOOT) && ctrl.f_stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state: boot countdown and MUL/DIV occupancy; a data wait freezes everything.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    md_cnt_d   = md_cnt_q;
    unique case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == 8'd0) state_d = S_RUN;
        else                    boot_cnt_d = boot_cnt_q - 8'd1;
      end
      S_RUN: begin
        // A 2-cycle op is fully covered by the start cycle, so S_MD is skipped.
        if (!dmem_wait && E_md_start && (MD_CYCLES > 2)) begin
          md_cnt_d = MdLoad;
          state_d  = S_MD;
        end
      end
      S_MD: begin
        if (!dmem_wait) begin
          if (md_cnt_q == 8'd1) state_d = S_RUN;
          else                  md_cnt_d = md_cnt_q - 8'd1;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Output decode in priority order; reset and boot bubble the whole pipe.
  always_comb begin
    ctrl = '0;
    if (rst || (state_q == S_BOOT)) begin
      ctrl.f_stall  = 1'b1;
      ctrl.fd_flush = 1'b1;
      ctrl.de_flush = 1'b1;
      ctrl.em_flush = 1'b1;
    end else if (dmem_wait) begin
      ctrl.f_stall  = 1'b1;
      ctrl.fd_stall = 1'b1;
      ctrl.de_stall = 1'b1;
      ctrl.em_stall = 1'b1;
      ctrl.mw_stall = 1'b1;
    end else if (md_busy) begin
      ctrl.f_stall  = 1'b1;
      ctrl.fd_stall = 1'b1;
      ctrl.de_stall = 1'b1;
      ctrl.em_flush = 1'b1;
    end else if (E_branch_taken) begin
      // Only reachable in S_RUN; the PC takes the target so fetch is not held.
      ctrl.fd_flush = 1'b1;
      ctrl.de_flush = 1'b1;
    end else if (load_use) begin
      ctrl.f_stall  = 1'b1;
      ctrl.fd_stall = 1'b1;
      ctrl.de_flush = 1'b1;
    end else if (imem_wait) begin
      ctrl.f_stall  = 1'b1;
      ctrl.fd_flush = 1'b1;
    end
  end

  assign F_stall   = ctrl.f_stall;
  assign FD_stall  = ctrl.fd_stall;
  assign FD_flush  = ctrl.fd_flush;
  assign DE_stall  = ctrl.de_stall;
  assign DE_flush  = ctrl.de_flush;
  assign EM_stall  = ctrl.em_stall;
  assign EM_flush  = ctrl.em_flush;
  assign MW_stall  = ctrl.mw_stall;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with default parameters.
module tb_pipeline_hazard_ctrl;

  // Expected control vector bit order: F,FDs,FDf,DEs,DEf,EMs,EMf,MWs.
  localparam logic [7:0] C_RST  = 8'b1010_1010;
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_LU   = 8'b1100_1000;
  localparam logic [7:0] C_MD   = 8'b1101_0010;
  localparam logic [7:0] C_DM   = 8'b1101_0101;
  localparam logic [7:0] C_BR   = 8'b0010_1000;
  localparam logic [7:0] C_IM   = 8'b1010_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  D_rs1 = '0, D_rs2 = '0, E_rd = '0;
  logic        E_mem_read = 1'b0, E_branch_taken = 1'b0, E_md_start = 1'b0;
  logic        imem_wait = 1'b0, dmem_wait = 1'b0;
  logic        F_stall, FD_stall, FD_flush, DE_stall, DE_flush, EM_stall, EM_flush, MW_stall;
  logic [31:0] stall_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [39:0] exp_q[$];
  string       tag_q[$];

  pipeline_hazard_ctrl #(
    .MD_CYCLES   (4),
    .BOOT_CYCLES (2),
    .CNT_W       (32)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .D_rs1          (D_rs1),
    .D_rs2          (D_rs2),
    .E_rd           (E_rd),
    .E_mem_read     (E_mem_read),
    .E_branch_taken (E_branch_taken),
    .E_md_start     (E_md_start),
    .imem_wait      (imem_wait),
    .dmem_wait      (dmem_wait),
    .F_stall        (F_stall),
    .FD_stall       (FD_stall),
    .FD_flush       (FD_flush),
    .DE_stall       (DE_stall),
    .DE_flush       (DE_flush),
    .EM_stall       (EM_stall),
    .EM_flush       (EM_flush),
    .MW_stall       (MW_stall),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus and push what the DUT must show during that cycle.
  task automatic drive(input string tag, input logic r, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic mr,
                       input logic br, input logic md, input logic im, input logic dm,
                       input logic [7:0] exp_ctrl, input logic [31:0] exp_cnt);
    @(posedge clk);
    #1;
    rst = r; D_rs1 = rs1; D_rs2 = rs2; E_rd = rd; E_mem_read = mr;
    E_branch_taken = br; E_md_start = md; imem_wait = im; dmem_wait = dm;
    exp_q.push_back({exp_ctrl, exp_cnt});
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag, input logic [7:0] exp_ctrl, input logic [31:0] exp_cnt);
    drive(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_ctrl, exp_cnt);
  endtask

  // Compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [39:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, " ctrl"}, {56'd0, F_stall, FD_stall, FD_flush, DE_stall, DE_flush,
                                  EM_stall, EM_flush, MW_stall}, {56'd0, e[39:32]});
      check({t, " stall_cnt"}, {32'd0, stall_cnt}, {32'd0, e[31:0]});
    end
  end

  initial begin
    // Reset held, then released: two boot cycles, then idle.
    drive("rst0", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RST, 32'd0);
    drive("rst1", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, C_RST, 32'd0);
    drive("boot0", 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, C_RST, 32'd0);
    idle("boot1", C_RST, 32'd0);
    idle("run0", C_NONE, 32'd0);

    // Load-use on rs1, on rs2, and the x0 exemption.
    drive("lu_rs1", 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 32'd0);
    idle("lu_rs1_after", C_NONE, 32'd1);
    drive("lu_x0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 32'd1);
    drive("lu_norm", 1'b0, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_NONE, 32'd1);
    drive("lu_rs2", 1'b0, 5'd1, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 32'd1);
    idle("lu_rs2_after", C_NONE, 32'd2);

    // Fetch wait alone, then combined with load-use (FD holds).
    drive("imem", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, C_IM, 32'd2);
    drive("imem_lu", 1'b0, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, C_LU, 32'd3);
    idle("imem_after", C_NONE, 32'd4);

    // Branch beats load-use and fetch wait.
    drive("br_lu_im", 1'b0, 5'd9, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, C_BR, 32'd4);
    idle("br_after", C_NONE, 32'd4);

    // MUL/DIV: start held high is ignored while busy; 3 stalled cycles.
    drive("md_t0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MD, 32'd4);
    drive("md_t1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, C_MD, 32'd5);
    drive("md_t2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MD, 32'd6);
    idle("md_t3", C_NONE, 32'd7);

    // MUL/DIV with a 2-cycle data wait inside; release moves to T+5.
    drive("mdw_t0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MD, 32'd7);
    drive("mdw_t1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_DM, 32'd8);
    drive("mdw_t2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, C_DM, 32'd9);
    idle("mdw_t3", C_MD, 32'd10);
    idle("mdw_t4", C_MD, 32'd11);
    idle("mdw_t5", C_NONE, 32'd12);

    // Data wait in plain run, and a data wait blocking a MUL/DIV start.
    drive("dmem", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, C_DM, 32'd12);
    drive("dmem_md", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, C_DM, 32'd13);
    idle("dmem_after", C_NONE, 32'd14);

    // Reset mid-MUL/DIV: reboot, counter cleared, operation not resumed.
    drive("mdr_t0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_MD, 32'd14);
    drive("mdr_rst", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_RST, 32'd15);
    idle("mdr_boot0", C_RST, 32'd0);
    idle("mdr_boot1", C_RST, 32'd0);
    idle("mdr_run", C_NONE, 32'd0);
    idle("mdr_run2", C_NONE, 32'd0);

    @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 time units");
    $fatal(1, "timeout");
  end

endmodule
